run_sequencer: RTL
==================

# run_sequencer

Parametrised run controller that drives the processor core's `enable` input with a programmable train of start pulses. It replaces hand-timed enable waveforms with a register-configured schedule. After each pulse it captures the core's result word into a small result FIFO for readback. It sits between the host/test harness and the processor top level, in the core's clock domain.

## Interface

Parameters:
- `DATA_W`, 32, width of the core result word and FIFO entries
- `DEPTH`, 8, result FIFO depth (power of two, ≥2)
- `CNT_W`, 16, width of pulse-count and gap counters

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  launch a run (sampled only in IDLE)
- `abort`  in  1  terminate a run in progress
- `pulse_count`  in  CNT_W  number of enable pulses in the run
- `pulse_width`  in  8  enable-high cycles per pulse
- `gap`  in  CNT_W  enable-low cycles after each pulse
- `enable_o`  out  1  to core `enable`
- `core_result`  in  DATA_W  core output word
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at normal run completion
- `rd_en`  in  1  pop FIFO head
- `rd_data`  out  DATA_W  FIFO head (first-word fall-through)
- `empty`  out  1  FIFO empty
- `overflow`  out  1  sticky, capture dropped on full FIFO

## Operation

- Reset values: `enable_o`=0, `busy`=0, `done`=0, `overflow`=0, `empty`=1, `rd_data`=0; FSM in IDLE; FIFO pointers and count cleared.
- FSM states: IDLE, PULSE, GAP.
  - IDLE: on `start`, latch `pulse_count`, `pulse_width`, `gap`; clear `overflow`. If latched count = 0, assert `done` next cycle and stay in IDLE. Otherwise go to PULSE.
  - PULSE: `enable_o`=1 for W cycles, then GAP.
  - GAP: `enable_o`=0 for G cycles. On the last GAP cycle, capture `core_result` into the FIFO and decrement the remaining count. Go to PULSE if count remains; otherwise go to IDLE with `done`.
- Width rules: a latched `pulse_width` of 0 is treated as 1. A latched `gap` of 0 is treated as 1.
- `start` asserted while busy is ignored. Config inputs may change mid-run without effect.
- `abort` in PULSE or GAP returns the FSM to IDLE next edge:
  - `enable_o` low from that edge
  - no capture, no `done`
  - FIFO contents are retained.
- Capture when FIFO is full: the word is dropped and `overflow` is set. `overflow` stays set until the next accepted `start` or reset.
- FIFO read:
  - `rd_en` with `empty`=1 is ignored.
  - Capture and `rd_en` on the same edge with the FIFO full: both take effect and the word is not dropped.
  - Same-edge capture and read with the FIFO empty: the read is ignored and the write proceeds.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Asynchronous reset mid-run forces all outputs to their reset values immediately.

## Timing

- `start` sampled at edge 0 → `busy`=1 and `enable_o`=1 from edge 1.
- Each pulse occupies W+G cycles. Capture occurs at the edge ending the last GAP cycle of each pulse.
- `done`=1 for one cycle starting at edge 1+N·(W+G). `busy` falls at the same edge.
- A new `start` is accepted in the same cycle `done` is high.
- Captured data is visible on `rd_data`/`empty` one edge after capture. `rd_data` advances one edge after `rd_en`.
- `abort` takes effect at the next edge. `enable_o` is registered, so it is glitch-free.

## Structure

- Package `run_seq_pkg`:
  - state enum `run_state_t` {IDLE, PULSE, GAP}
  - default parameter constants
- Sub-module `result_fifo` (DATA_W, DEPTH): synchronous FWFT FIFO with `wr_en`, `rd_en`, `full`, `empty`, `count`.
- Top-level contents: FSM, width/gap/pulse counters, capture and overflow logic.

## Test plan

- Basic run: N=3, W=3, G=97, `core_result` ramps by +1 each cycle from 0 → `enable_o` high at cycles 1–3, 101–103, 201–203. Captures are 100, 200, 300. `done` at cycle 301.
- Zero cases: N=0 → `done` at cycle 1, `enable_o` never high. W=0, G=0, N=2 → pulses at cycles 1 and 3, `done` at cycle 5.
- Overflow: DEPTH=8, N=10, no reads → 8 words held, `overflow`=1 after the 9th capture. Reading all 8 gives the first 8 captures in order. The next `start` clears `overflow`.
- Full plus simultaneous read: FIFO full, `rd_en` on the capture edge → no overflow, count stays 8, new word is at the tail.
- Abort and reset: `abort` during the 2nd PULSE → `enable_o` low next edge, 1 word in FIFO, no `done`. `reset` low mid-GAP → all outputs at reset values immediately, FIFO empty.
- Busy-start: `start` re-asserted mid-run with a different `pulse_count` → ignored, run completes with the original N.

Source files
------------

// File: rtl/run_seq_pkg.sv
// Shared types and default sizing for the run sequencer and its result FIFO.
package run_seq_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefDepth = 8;
  localparam int unsigned DefCntW  = 16;
  localparam int unsigned WidthW   = 8;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } run_state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured core results.
module result_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_wr;
  logic              do_rd;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A read on a full FIFO frees the slot the simultaneous write lands in.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/run_sequencer.sv
// Drives the core enable with a programmed train of pulses and captures the
// core result at the end of each pulse period into a readback FIFO.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  pulse_count,
  input  logic [7:0]        pulse_width,
  input  logic [CNT_W-1:0]  gap,
  output logic              enable_o,
  input  logic [DATA_W-1:0] core_result,
  output logic              busy,
  output logic              done,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              overflow
);

  localparam int unsigned TimerW   = (CNT_W > WidthW) ? CNT_W : WidthW;
  localparam int unsigned FifoCntW = $clog2(DEPTH) + 1;

  run_state_t         state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [WidthW-1:0]  width_q, width_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic               capture;
  logic [WidthW-1:0]  width_eff;
  logic [CNT_W-1:0]   gap_eff;
  logic               fifo_full;
  logic [FifoCntW-1:0] fifo_count;
  logic               unused_fifo_count;

  // Zero-length phases would stall the counters, so they run as one cycle.
  assign width_eff = (pulse_width == '0) ? WidthW'(1) : pulse_width;
  assign gap_eff   = (gap == '0) ? CNT_W'(1) : gap;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    width_d  = width_q;
    gap_d    = gap_q;
    timer_d  = timer_q;
    enable_d = enable_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    capture  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          width_d = width_eff;
          gap_d   = gap_eff;
          rem_d   = pulse_count;
          ovf_d   = 1'b0;
          if (pulse_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = PULSE;
            enable_d = 1'b1;
            busy_d   = 1'b1;
            timer_d  = TimerW'(width_eff) - TimerW'(1);
          end
        end
      end

      PULSE: begin
        if (abort) begin
          state_d  = IDLE;
          enable_d = 1'b0;
          busy_d   = 1'b0;
        end else if (timer_q == '0) begin
          state_d  = GAP;
          enable_d = 1'b0;
          timer_d  = TimerW'(gap_q) - TimerW'(1);
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end

      GAP: begin
        if (abort) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
        end else if (timer_q == '0) begin
          capture = 1'b1;
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = PULSE;
            enable_d = 1'b1;
            timer_d  = TimerW'(width_q) - TimerW'(1);
          end
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

    // Full FIFO only drops the word when no read frees a slot on this edge.
    if (capture && fifo_full && !rd_en) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      width_q  <= '0;
      gap_q    <= '0;
      timer_q  <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      width_q  <= width_d;
      gap_q    <= gap_d;
      timer_q  <= timer_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (capture),
    .wr_data (core_result),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;

  assign enable_o = enable_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
